// File: rtl/mygo_chan_pkg.sv
// Shared definitions for mygo channel FIFOs: default channel geometry,
// the channel signal bundle, and a width helper that never returns zero bits.
package mygo_chan_pkg;

  localparam int CHAN_WIDTH = 32;
  localparam int CHAN_DEPTH = 2;

  // Pointer width for a ring of n slots; a single-slot ring still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [CHAN_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
  } chan_bus_t;

endpackage

// File: rtl/mygo_ring_ptr.sv
// Modulo-DEPTH ring pointer: advances on inc and wraps to 0 after DEPTH-1,
// using an explicit compare so non-power-of-two depths work.
module mygo_ring_ptr
  import mygo_chan_pkg::*;
#(
  parameter int DEPTH = CHAN_DEPTH,
  parameter int PTR_W = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/mygo_chan_fifo.sv
// Valid/ready channel FIFO between two mygo processes, with occupancy and
// high-water reporting. Handshake signals decode from registered state only.
module mygo_chan_fifo
  import mygo_chan_pkg::*;
#(
  parameter int WIDTH = CHAN_WIDTH,
  parameter int DEPTH = CHAN_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] high_water
);

  localparam int               PTR_W = clog2_min1(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] hw_q;
  logic             push;
  logic             pop;

  // No bypass either way: full-with-pop still refuses, empty never falls through.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  mygo_ring_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  mygo_ring_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // NOTE: the storage array is deliberately not reset; resetting the pointers
  // and count already discards its contents, and an unreset array maps to RAM.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      hw_q    <= '0;
    end else begin
      count_q <= count_d;
      if (count_d > hw_q) begin
        hw_q <= count_d;
      end
    end
  end

  assign out_data   = mem[rd_ptr];
  assign count      = count_q;
  assign high_water = hw_q;

endmodule

// File: tb/tb_mygo_chan_fifo.sv
// Self-checking bench: four FIFO instances (depths 4, 2, 1, 3) driven one at a
// time and compared every cycle against a queue-based channel model.
module tb_mygo_chan_fifo;

  localparam int W = 16;
  localparam int N = 4;
  localparam int DEPTHS [N] = '{4, 2, 1, 3};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] in_data    [N];
  logic         in_valid   [N];
  logic         in_ready   [N];
  logic [W-1:0] out_data   [N];
  logic         out_valid  [N];
  logic         out_ready  [N];
  logic [2:0]   count      [N];
  logic [2:0]   high_water [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D  = DEPTHS[g];
    localparam int CW = $clog2(D + 1);
    logic [CW-1:0] c;
    logic [CW-1:0] h;
    mygo_chan_fifo #(.WIDTH(W), .DEPTH(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .out_data   (out_data[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .count      (c),
      .high_water (h)
    );
    assign count[g]      = 3'(c);
    assign high_water[g] = 3'(h);
  end

  // Reference model: contents of each channel as a queue, plus peak occupancy.
  logic [W-1:0] mq [N][$];
  int           hw_m [N];
  int           checks = 0;
  int           errors = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      hw_m[i] = 0;
    end
  endtask

  // One clock cycle on instance i: drive, compare outputs with the model,
  // apply the accepted handshakes to the model, advance past the edge.
  task automatic cycle(input int i, input logic v, input logic [W-1:0] d, input logic r,
                       output logic pushed, output logic popped, output logic [W-1:0] pop_val);
    logic exp_ready, exp_valid;
    in_valid[i]  = v;
    in_data[i]   = d;
    out_ready[i] = r;
    #1;
    exp_ready = (mq[i].size() != DEPTHS[i]);
    exp_valid = (mq[i].size() != 0);
    checks++;
    if (in_ready[i] !== exp_ready) begin
      errors++;
      $display("FAIL in_ready inst%0d got %b want %b", i, in_ready[i], exp_ready);
    end
    checks++;
    if (out_valid[i] !== exp_valid) begin
      errors++;
      $display("FAIL out_valid inst%0d got %b want %b", i, out_valid[i], exp_valid);
    end
    checks++;
    if (count[i] !== 3'(mq[i].size())) begin
      errors++;
      $display("FAIL count inst%0d got %0d want %0d", i, count[i], mq[i].size());
    end
    checks++;
    if (high_water[i] !== 3'(hw_m[i])) begin
      errors++;
      $display("FAIL high_water inst%0d got %0d want %0d", i, high_water[i], hw_m[i]);
    end
    if (exp_valid) begin
      checks++;
      if (out_data[i] !== mq[i][0]) begin
        errors++;
        $display("FAIL out_data inst%0d got %h want %h", i, out_data[i], mq[i][0]);
      end
    end
    pushed  = v && exp_ready;
    popped  = r && exp_valid;
    pop_val = exp_valid ? mq[i][0] : '0;
    if (popped) void'(mq[i].pop_front());
    if (pushed) mq[i].push_back(d);
    if (mq[i].size() > hw_m[i]) hw_m[i] = mq[i].size();
    @(posedge clk);
    #1;
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_model();
  endtask

  task automatic test_reset();
    do_reset(2);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || count[i] !== 3'd0 || high_water[i] !== 3'd0) begin
        errors++;
        $display("FAIL reset_state inst%0d got rdy=%b vld=%b cnt=%0d hw=%0d want 1 0 0 0",
                 i, in_ready[i], out_valid[i], count[i], high_water[i]);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic p, q;
    logic [W-1:0] pv;
    logic [W-1:0] got [$];
    bit sent5 = 0;
    for (int k = 1; k <= 4; k++) begin
      cycle(0, 1'b1, W'(k), 1'b0, p, q, pv);
      checks++;
      if (p !== 1'b1) begin
        errors++;
        $display("FAIL fill_accept value %0d got %b want 1", k, p);
      end
    end
    checks++;
    if (in_ready[0] !== 1'b0 || count[0] !== 3'd4 || high_water[0] !== 3'd4) begin
      errors++;
      $display("FAIL full_state got rdy=%b cnt=%0d hw=%0d want 0 4 4", in_ready[0], count[0], high_water[0]);
    end
    repeat (2) begin
      cycle(0, 1'b1, W'(5), 1'b0, p, q, pv);
      checks++;
      if (p !== 1'b0) begin
        errors++;
        $display("FAIL full_refuse got accepted=%b want 0", p);
      end
    end
    for (int t = 0; t < 20 && got.size() < 5; t++) begin
      cycle(0, !sent5, W'(5), 1'b1, p, q, pv);
      if (p) sent5 = 1;
      if (q) got.push_back(pv);
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL drain_count got %0d want 5", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== W'(k + 1)) begin
        errors++;
        $display("FAIL drain_order slot %0d got %0d want %0d", k, got[k], k + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic p, q;
    logic [W-1:0] pv;
    int next_in = 0, next_out = 0, first_push = -1, last_pop = -1;
    for (int t = 0; t < 40 && next_out < 10; t++) begin
      checks++;
      if (count[1] > 3'd1) begin
        errors++;
        $display("FAIL stream_count cycle %0d got %0d want <=1", t, count[1]);
      end
      cycle(1, next_in < 10, W'(next_in), 1'b1, p, q, pv);
      if (p) begin
        if (first_push < 0) first_push = t;
        next_in++;
      end
      if (q) begin
        checks++;
        if (pv !== W'(next_out) || (last_pop >= 0 ? t != last_pop + 1 : t != first_push + 1)) begin
          errors++;
          $display("FAIL stream_pop cycle %0d got value %0d want %0d (prev pop %0d, first push %0d)",
                   t, pv, next_out, last_pop, first_push);
        end
        last_pop = t;
        next_out++;
      end
    end
    checks++;
    if (next_out != 10) begin
      errors++;
      $display("FAIL stream_total got %0d want 10", next_out);
    end
  endtask

  task automatic test_depth1();
    logic p, q;
    logic [W-1:0] pv;
    int next_in = 0, next_out = 0, last_push = -1;
    for (int t = 0; t < 40 && next_out < 5; t++) begin
      cycle(2, next_in < 5, W'(next_in), 1'b1, p, q, pv);
      if (p) begin
        checks++;
        if (last_push >= 0 && t != last_push + 2) begin
          errors++;
          $display("FAIL d1_spacing cycle %0d got gap %0d want 2", t, t - last_push);
        end
        last_push = t;
        next_in++;
      end
      if (q) begin
        checks++;
        if (pv !== W'(next_out)) begin
          errors++;
          $display("FAIL d1_order got %0d want %0d", pv, next_out);
        end
        next_out++;
      end
    end
    checks++;
    if (next_out != 5 || high_water[2] !== 3'd1) begin
      errors++;
      $display("FAIL d1_done got outputs=%0d hw=%0d want 5 1", next_out, high_water[2]);
    end
  endtask

  task automatic test_wrap();
    logic p, q;
    logic [W-1:0] pv;
    logic [W-1:0] sent [$];
    int sent_n = 0, recv_n = 0;
    for (int k = 0; k < 10; k++) sent.push_back(W'($urandom));
    for (int t = 0; t < 200 && recv_n < 10; t++) begin
      cycle(3, sent_n < 10, (sent_n < 10) ? sent[sent_n] : '0, 1'($urandom_range(0, 1)), p, q, pv);
      if (p) sent_n++;
      if (q) begin
        checks++;
        if (pv !== sent[recv_n]) begin
          errors++;
          $display("FAIL wrap_order slot %0d got %h want %h", recv_n, pv, sent[recv_n]);
        end
        recv_n++;
      end
    end
    checks++;
    if (recv_n != 10) begin
      errors++;
      $display("FAIL wrap_total got %0d want 10 within budget", recv_n);
    end
  endtask

  task automatic test_mid_reset();
    logic p, q;
    logic [W-1:0] pv;
    for (int k = 0; k < 3; k++) cycle(0, 1'b1, W'(16'h30 + k), 1'b0, p, q, pv);
    checks++;
    if (count[0] !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_count got %0d want 3", count[0]);
    end
    rst          = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = W'(16'h99);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    clear_model();
    checks++;
    if (count[0] !== 3'd0 || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || high_water[0] !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset_state got cnt=%0d vld=%b rdy=%b hw=%0d want 0 0 1 0",
               count[0], out_valid[0], in_ready[0], high_water[0]);
    end
    cycle(0, 1'b1, W'(16'h77), 1'b0, p, q, pv);
    cycle(0, 1'b0, '0, 1'b1, p, q, pv);
    checks++;
    if (q !== 1'b1 || pv !== W'(16'h77) || count[0] !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset_first got popped=%b value=%h cnt=%0d want 1 0077 0", q, pv, count[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b0;
    end
    clear_model();
    @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_depth1();
    test_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
